// File: rtl/mult8_sequencer.sv
// 8x8 unsigned multiply sequenced through one shared 4-bit multiplier.
// Optional ZERO_SKIP_EN: skip partial products with a zero nibble operand.
module mult8_sequencer #(
  parameter int Width = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*Width-1:0] a_in,
  input  logic [2*Width-1:0] b_in,
  output logic               busy,
  output logic               done,
  output logic [4*Width-1:0] result,
  output logic [Width-1:0]   mul_a,
  output logic [Width-1:0]   mul_b,
  input  logic [2*Width-1:0] mul_p
);

  typedef enum logic [2:0] {
    IDLE, PP0, PP1, PP2, PP3, DONE
  } state_t;

  state_t state, state_nx;

  logic [2*Width-1:0] a_r, b_r;
  logic [2*Width-1:0] a_src, b_src;
  logic [4*Width-1:0] acc, acc_nx;
  logic [4*Width-1:0] pp_ext;
  logic [3:0]         nz, rem, cand;
  logic               accept, load;

  assign pp_ext = {{(2*Width){1'b0}}, mul_p};
  assign accept = (state == IDLE) && start;

  // In IDLE the operands are still on the inputs, not in a_r/b_r.
  assign a_src = (state == IDLE) ? a_in : a_r;
  assign b_src = (state == IDLE) ? b_in : b_r;

`ifdef ZERO_SKIP_EN
  assign nz[0] = (|a_src[Width-1:0]) & (|b_src[Width-1:0]);
  assign nz[1] = (|a_src[Width-1:0]) & (|b_src[2*Width-1:Width]);
  assign nz[2] = (|a_src[2*Width-1:Width]) & (|b_src[Width-1:0]);
  assign nz[3] = (|a_src[2*Width-1:Width]) & (|b_src[2*Width-1:Width]);
`else
  assign nz = 4'hf;
`endif

  assign cand = rem & nz;

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    rem      = 4'h0;
    mul_a    = '0;
    mul_b    = '0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        rem    = 4'b1111;
        acc_nx = '0;
      end
      PP0: begin
        rem    = 4'b1110;
        busy   = 1'b1;
        mul_a  = a_r[Width-1:0];
        mul_b  = b_r[Width-1:0];
        acc_nx = acc + pp_ext;
      end
      PP1: begin
        rem    = 4'b1100;
        busy   = 1'b1;
        mul_a  = a_r[Width-1:0];
        mul_b  = b_r[2*Width-1:Width];
        acc_nx = acc + (pp_ext << Width);
      end
      PP2: begin
        rem    = 4'b1000;
        busy   = 1'b1;
        mul_a  = a_r[2*Width-1:Width];
        mul_b  = b_r[Width-1:0];
        acc_nx = acc + (pp_ext << Width);
      end
      PP3: begin
        busy   = 1'b1;
        mul_a  = a_r[2*Width-1:Width];
        mul_b  = b_r[2*Width-1:Width];
        acc_nx = acc + (pp_ext << (2 * Width));
      end
      DONE: done = 1'b1;
      default: ;
    endcase
    if (state == DONE) begin
      state_nx = IDLE;
    end else if (state != IDLE || start) begin
      if (cand[0])      state_nx = PP0;
      else if (cand[1]) state_nx = PP1;
      else if (cand[2]) state_nx = PP2;
      else if (cand[3]) state_nx = PP3;
      else              state_nx = DONE;
    end
  end

  assign load = (state != DONE) && (state_nx == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_r <= a_in;
        b_r <= b_in;
      end
      if (accept || busy) acc <= acc_nx;
      if (load) result <= acc_nx;
    end
  end

endmodule

// File: tb/tb_mult8_sequencer.sv
// Bench for mult8_sequencer: directed cases plus random operands.
// Reference: product by plain arithmetic, visited nibble pairs from operands.
module tb_mult8_sequencer;

`ifdef ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic        busy, done;
  logic [15:0] result;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_p;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = -1;

  mult8_sequencer #(.Width(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  // Model of the external combinational 4x4 multiplier.
  assign mul_p = {4'b0, mul_a} * {4'b0, mul_b};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input bit hold, input bit poke);
    logic [15:0] exp_p;
    logic [3:0]  an, bn;
    int          nvis;
    exp_p = 16'(a) * 16'(b);
    nvis  = 0;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    tick();
    if (!hold) start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      an = (k >= 2) ? a[7:4] : a[3:0];
      bn = (k % 2 == 1) ? b[7:4] : b[3:0];
      if (!SKIP || (an != 0 && bn != 0)) begin
        nvis++;
        chk("busy_pp", busy, 1);
        chk("mul_a", mul_a, an);
        chk("mul_b", mul_b, bn);
        chk("done_pp", done, 0);
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        if (poke) start = 1'b1;
        tick();
      end
    end
    start = hold;
    chk("done", done, 1);
    chk("busy_done", busy, 0);
    chk("result", result, exp_p);
    chk("mul_idle", {mul_a, mul_b}, 0);
    if (hold && last_done >= 0)
      chk("period", cyc - last_done, nvis + 2);
    last_done = cyc;
    tick();
    chk("done_clr", done, 0);
    chk("busy_idle", busy, 0);
    chk("result_hold", result, exp_p);
  endtask

  initial begin
    logic [7:0] ra, rb;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_mul", {mul_a, mul_b}, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_noop", busy, 0);

    do_op(8'h12, 8'h34, 1'b0, 1'b0);
    chk("t1_val", result, 16'h03a8);
    do_op(8'hff, 8'hff, 1'b0, 1'b0);
    chk("t2_val", result, 16'hfe01);
    do_op(8'h10, 8'h01, 1'b0, 1'b0);
    do_op(8'h00, 8'h5a, 1'b0, 1'b0);

    do_op(8'h05, 8'h04, 1'b0, 1'b1);
    chk("t4_first", result, 16'h0014);
    do_op(8'h0f, 8'h03, 1'b0, 1'b0);
    chk("t4_second", result, 16'h002d);

    // Reset in the middle of an operation.
    start = 1'b1;
    a_in  = 8'hc0;
    b_in  = 8'hd0;
    tick();
    start = 1'b0;
    if (!SKIP) begin
      tick();
      tick();
    end
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_result", result, 0);
    chk("mrst_mul", {mul_a, mul_b}, 0);
    tick();
    chk("mrst_hold", busy, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", busy, 0);
    do_op(8'h0c, 8'h0d, 1'b0, 1'b0);
    chk("t5_val", result, 16'h009c);

    // Start held high: a new operation each time FSM reaches IDLE.
    last_done = -1;
    for (int i = 0; i < 4; i++) do_op(8'h03, 8'h05, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    chk("hold_stop", busy, 0);

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ra[3:0] = 4'h0;
      if ($urandom_range(0, 3) == 0) rb[7:4] = 4'h0;
      if ($urandom_range(0, 7) == 0) ra = 8'h00;
      do_op(ra, rb, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
